uart_tx: RTL
============

# uart_tx

Write-only UART transmitter peripheral behind the system bus decoder's UART chip-select. Each bus write to the UART window pushes one byte into an internal FIFO. A serializer drains the FIFO onto `uart_txd` as 8N1 frames: one start bit, 8 data bits LSB-first, one stop bit. Overflow and read attempts are reported back to the decoder through `uart_error` in the same cycle.

## Interface
Parameters:
- `CLK_DIV`, 16 — clock cycles per bit; legal values are ≥2.
- `FIFO_DEPTH`, 8 — number of FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `uart_cen`  in  1  chip-select from the bus decoder; valid for the current cycle only.
- `uart_wr`  in  1  access direction: 1 = write, 0 = read.
- `uart_wdata`  in  8  byte to transmit.
- `uart_error`  out  1  combinational access-error response to the decoder.
- `uart_txd`  out  1  serial output; idles high.
- `tx_busy`  out  1  high whenever the serializer is not in IDLE.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

## Operation
- Push condition: `push = uart_cen & uart_wr & ~full`.
  - `full` is derived from the registered count before any same-cycle pop.
  - A write while full drops the byte.
- Error output: `uart_error = uart_cen & (~uart_wr | full)`.
  - Reads always report an error, because the block has no readable registers.
- Pop condition: `pop = ~empty & (state==IDLE | (state==STOP & bit_last))`.
  - `bit_last` means the bit counter equals 0.
  - A pop loads the head byte into a 8-bit shift register and moves the serializer to START.
- Back-to-back frames leave no idle gap.
- If a push and a pop happen in the same cycle, the count is unchanged and both pointers advance.
- Serializer states:
  - IDLE: `txd=1`. On pop, go to START.
  - START: `txd=0` for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `txd=shift[0]`. Every CLK_DIV cycles, shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: `txd=1` for CLK_DIV cycles. At the end, go to START if pop occurs, otherwise go to IDLE.
- Bit counter:
  - Loaded with CLK_DIV-1 on every state or bit entry.
  - Decrements each cycle.
  - `bit_last` marks the counter at 0.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
- Count range is 0..FIFO_DEPTH.

## Timing
Reset values:
- `uart_txd=1`, `tx_busy=0`, `fifo_level=0`.
- State is IDLE; pointers and counters are 0.
- `uart_error` is combinational and reflects its inputs even during reset. The FIFO is full-cleared, so only reads flag an error.

Latency and frame timing:
- Write accepted at edge N → `fifo_level` increments after N.
- If the FIFO was empty and state was IDLE, pop occurs at edge N+1 and `uart_txd` falls after N+1.
- Frame length is exactly 10·CLK_DIV cycles.
- During a continuous stream, the start bit of frame k+1 begins the cycle after the last stop-bit cycle of frame k.

Boundary cases:
- Full FIFO plus a simultaneous pop: a write in that cycle is still rejected with an error. This keeps the timing path from pop to error short.
- Reset asserted mid-frame:
  - `uart_txd` goes high immediately (asynchronously).
  - FIFO contents are discarded.
  - After reset releases, the next byte starts a fresh frame.
- `uart_cen` low: there is no side effect, whatever `uart_wr` or `uart_wdata` hold.

## Structure
- The shared defines header holds:
  - the serializer state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - the UART frame constants (8 data bits, 1 stop bit).
- One sub-module, `sync_fifo`, parameterised by width and depth.
  - Ports: push/pop/wdata/rdata/full/empty/count.
  - Includes the same-cycle push+pop rule.
  - Reusable for a future RX path.
- The serializer FSM, bit counter and shift register live in `uart_tx` itself.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=8.
- Single write of 0x55 → frame bits in order 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; 40 cycles total; `tx_busy` high for 40 cycles; `fifo_level` goes 1→0 one cycle after the write.
- Nine consecutive writes 0x00..0x08 while IDLE → the first is popped immediately, so all 9 are accepted without error; a 10th write the next cycle sees level 8 → `uart_error=1` and the byte is dropped.
- Fill 8 entries, then write while the serializer pops at the end of a STOP → `uart_error=1` and `fifo_level` ends at 7.
- Stream 0xA5 then 0x3C → the second start bit begins exactly 40 cycles after the first, with no idle-high gap.
- Read access (`uart_cen=1`, `uart_wr=0`) → `uart_error=1` in the same cycle; `fifo_level` and `uart_txd` are unchanged.
- Assert `rst_n=0` during DATA bit 3 → `uart_txd=1` within the same cycle, `fifo_level=0`, `tx_busy=0`; after release, a write of 0xFF produces a clean 40-cycle frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: serializer state encodings
// and 8N1 frame constants.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count. The head entry is visible
// combinationally on rdata so a consumer can load it in the same cycle it pops.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_reg;
    logic [AW-1:0]    rptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rptr_reg];
    assign count   = count_reg;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) wptr_reg <= wptr_reg + 1'b1;
            if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Write-only 8N1 UART transmitter: bus writes fill a FIFO that a bit-timed
// serializer drains back-to-back onto uart_txd.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_cen,
    input  logic                          uart_wr,
    input  logic [7:0]                    uart_wdata,
    output logic                          uart_error,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CLK_DIV - 1);

    tx_state_e       state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      idx_reg, idx_next;
    logic [7:0]      shift_reg, shift_next;
    logic            txd;

    logic            full;
    logic            empty;
    logic [7:0]      head;
    logic            push;
    logic            pop;
    logic            bit_last;
    logic            stop_done;

    // Error path depends only on the registered full flag, never on pop.
    assign push       = uart_cen & uart_wr & ~full;
    assign uart_error = uart_cen & (~uart_wr | full);

    assign bit_last  = (cnt_reg == '0);
    assign stop_done = (state_reg == STOP) & bit_last & (idx_reg == 3'(STOP_BITS - 1));
    assign pop       = ~empty & ((state_reg == IDLE) | stop_done);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (uart_wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = bit_last ? cnt_reg : cnt_reg - 1'b1;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        txd        = 1'b1;
        case (state_reg)
            IDLE: begin
                txd = 1'b1;
                if (pop) begin
                    state_next = START;
                    cnt_next   = CNT_RELOAD;
                    idx_next   = '0;
                    shift_next = head;
                end
            end
            START: begin
                txd = 1'b0;
                if (bit_last) begin
                    state_next = DATA;
                    cnt_next   = CNT_RELOAD;
                    idx_next   = '0;
                end
            end
            DATA: begin
                txd = shift_reg[0];
                if (bit_last) begin
                    cnt_next = CNT_RELOAD;
                    if (idx_reg == 3'(DATA_BITS - 1)) begin
                        state_next = STOP;
                        idx_next   = '0;
                    end else begin
                        shift_next = shift_reg >> 1;
                        idx_next   = idx_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                txd = 1'b1;
                if (bit_last) begin
                    cnt_next = CNT_RELOAD;
                    if (!stop_done) begin
                        idx_next = idx_reg + 1'b1;
                    end else if (pop) begin
                        // Next frame's start bit follows the last stop cycle directly.
                        state_next = START;
                        idx_next   = '0;
                        shift_next = head;
                    end else begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign uart_txd = txd;
    assign tx_busy  = (state_reg != IDLE);

endmodule
